// File: rtl/wb_master_if.sv
// Command/response port and strobe/ack peripheral bus of wb_master, bundled into one interface.
// The master modport is the initiator's view; slave is the sequencer-plus-responder side.
interface wb_master_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_write;
    logic [1:0] cmd_addr;
    logic [7:0] cmd_wdata;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic       rsp_err;
    logic [1:0] wb_addr;
    logic [7:0] wb_data_out;
    logic [7:0] wb_data_in;
    logic       wb_we;
    logic       wb_clk;
    logic       wb_stb;
    logic       wb_ack;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, wb_data_in, wb_ack,
        output cmd_ready, rsp_valid, rsp_data, rsp_err,
               wb_addr, wb_data_out, wb_we, wb_clk, wb_stb
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, wb_data_in, wb_ack,
        input  cmd_ready, rsp_valid, rsp_data, rsp_err,
               wb_addr, wb_data_out, wb_we, wb_clk, wb_stb
    );
endinterface

// File: rtl/wb_master.sv
// Single-outstanding strobe/ack bus initiator with a per-phase timeout so a dead responder
// cannot hang the requester. Bus direction uses the peripheral encoding (wb_we: 0 = write).
module wb_master #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    wb_master_if.master bus
);
    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT);

    typedef enum logic [2:0] {IDLE, REQ, REL, ABORT, DONE} state_t;

    state_t        state;
    logic [TW-1:0] timer;
    logic [1:0]    addr_q;
    logic [7:0]    wdata_q;
    logic          we_q;
    logic          stb_q;
    logic          clk_q;
    logic          rsp_valid_q;
    logic          rsp_err_q;
    logic [7:0]    rsp_data_q;
    logic          cmd_ready;

    // A lingering ack from the previous transfer must clear before a new strobe goes out.
    assign cmd_ready       = (state == IDLE) && !bus.wb_ack;
    assign bus.cmd_ready   = cmd_ready;
    assign bus.wb_addr     = addr_q;
    assign bus.wb_data_out = wdata_q;
    assign bus.wb_we       = we_q;
    assign bus.wb_stb      = stb_q;
    assign bus.wb_clk      = clk_q;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_err     = rsp_err_q;
    assign bus.rsp_data    = rsp_data_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            timer       <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            we_q        <= 1'b0;
            stb_q       <= 1'b0;
            clk_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_data_q  <= 8'h00;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.cmd_valid && cmd_ready) begin
                        addr_q  <= bus.cmd_addr;
                        wdata_q <= bus.cmd_wdata;
                        we_q    <= !bus.cmd_write;
                        stb_q   <= 1'b1;
                        clk_q   <= 1'b1;
                        timer   <= '0;
                        state   <= REQ;
                    end
                end
                REQ: begin
                    if (bus.wb_ack) begin
                        if (we_q)
                            rsp_data_q <= bus.wb_data_in;
                        clk_q <= 1'b0;
                        timer <= '0;
                        state <= REL;
                    end else if (timer == TMAX) begin
                        state <= ABORT;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                REL: begin
                    // Ack was high when we entered; only a later low level completes the transfer.
                    if (!bus.wb_ack) begin
                        stb_q       <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b0;
                        state       <= DONE;
                    end else if (timer == TMAX) begin
                        state <= ABORT;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                ABORT: begin
                    stb_q       <= 1'b0;
                    clk_q       <= 1'b0;
                    rsp_valid_q <= 1'b1;
                    rsp_err_q   <= 1'b1;
                    state       <= DONE;
                end
                DONE: begin
                    rsp_valid_q <= 1'b0;
                    rsp_err_q   <= 1'b0;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // The transfer-phase strobe only ever rises inside a selected cycle.
    a_clk_in_stb: assert property (@(posedge clk) disable iff (reset) clk_q |-> stb_q);
    a_err_qual:   assert property (@(posedge clk) disable iff (reset) rsp_err_q |-> rsp_valid_q);
endmodule

// File: tb/tb_wb_master.sv
// Bench for wb_master: a UART-style responder with random ack/release delays on one instance
// (TIMEOUT=255) and a bench-driven ack on a second instance (TIMEOUT=4) for abort and reset cases.
module tb_wb_master;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a, rst_b;
    wb_master_if a_if();
    wb_master_if b_if();

    wb_master #(.TIMEOUT(255)) u_dut_a (.clk(clk), .reset(rst_a), .bus(a_if.master));
    wb_master #(.TIMEOUT(4))   u_dut_b (.clk(clk), .reset(rst_b), .bus(b_if.master));

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Responder A: raises ack ack_dly cycles after seeing the strobe, drops it rel_dly cycles
    // after wb_clk falls; commits writes into its register file on the ack.
    int unsigned ack_dly = 1, rel_dly = 1;
    int unsigned cnt;
    logic [7:0]  mem [4];

    always @(posedge clk or posedge rst_a) begin
        if (rst_a) begin
            a_if.wb_ack <= 1'b0;
            cnt         <= 0;
            mem[0] <= 8'h11; mem[1] <= 8'h3C; mem[2] <= 8'h5A; mem[3] <= 8'hC3;
        end else if (a_if.wb_stb && a_if.wb_clk && !a_if.wb_ack) begin
            if (cnt + 1 >= ack_dly) begin
                a_if.wb_ack <= 1'b1;
                cnt         <= 0;
                if (!a_if.wb_we) mem[a_if.wb_addr] <= a_if.wb_data_out;
            end else cnt <= cnt + 1;
        end else if (!a_if.wb_clk && a_if.wb_ack) begin
            if (cnt + 1 >= rel_dly) begin
                a_if.wb_ack <= 1'b0;
                cnt         <= 0;
            end else cnt <= cnt + 1;
        end
    end
    assign a_if.wb_data_in = mem[a_if.wb_addr];

    // Reference: register contents and the read data the requester should be holding.
    logic [7:0] ref_mem [4] = '{8'h11, 8'h3C, 8'h5A, 8'hC3};
    logic [7:0] last_rd = 8'h00;

    task automatic txn_a(input bit wr, input logic [1:0] ad, input logic [7:0] wd,
                         input int unsigned a, input int unsigned r);
        int  lat;
        bit  seen, stable;
        ack_dly = a;
        rel_dly = r;
        a_if.cmd_valid = 1'b1; a_if.cmd_write = wr; a_if.cmd_addr = ad; a_if.cmd_wdata = wd;
        for (int i = 0; i < 20 && !a_if.cmd_ready; i++) tick();
        check("a_ready", a_if.cmd_ready, 1);
        tick();
        a_if.cmd_valid = 1'b0;
        check("a_strobes", {a_if.wb_stb, a_if.wb_clk}, 2'b11);
        check("a_addr_we", {a_if.wb_addr, a_if.wb_we}, {ad, !wr});
        if (wr) check("a_wdata", a_if.wb_data_out, wd);
        seen = 0; stable = 1;
        for (lat = 1; lat <= 60; lat++) begin
            tick();
            if (a_if.wb_addr !== ad || a_if.wb_we !== !wr || (wr && a_if.wb_data_out !== wd)) stable = 0;
            if (a_if.rsp_valid) begin seen = 1; break; end
        end
        if (wr) ref_mem[ad] = wd;
        else    last_rd = ref_mem[ad];
        check("a_rsp_seen", seen, 1);
        check("a_latency", lat, a + r + 2);
        check("a_err", a_if.rsp_err, 0);
        check("a_rdata", a_if.rsp_data, last_rd);
        check("a_stable", stable, 1);
        check("a_stb_off", a_if.wb_stb, 0);
        tick();
        check("a_pulse", a_if.rsp_valid, 0);
        check("a_hold", a_if.rsp_data, last_rd);
        tick();
        check("a_ready_again", a_if.cmd_ready, 1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1);
    end

    initial begin
        int          lat, acc_n, low, pulses;
        int          acc_cyc [3];
        int          gap_low [3];
        logic [7:0]  bw [3];
        rst_a = 1'b1; rst_b = 1'b1;
        a_if.cmd_valid = 0; a_if.cmd_write = 0; a_if.cmd_addr = 0; a_if.cmd_wdata = 0;
        b_if.cmd_valid = 0; b_if.cmd_write = 0; b_if.cmd_addr = 0; b_if.cmd_wdata = 0;
        b_if.wb_ack = 0; b_if.wb_data_in = 8'hEE;
        repeat (2) tick();
        check("rst_a_outs", {a_if.rsp_valid, a_if.rsp_err, a_if.wb_stb, a_if.wb_clk, a_if.wb_we,
                             a_if.wb_addr, a_if.wb_data_out, a_if.rsp_data}, 0);
        check("rst_b_outs", {b_if.rsp_valid, b_if.rsp_err, b_if.wb_stb, b_if.wb_clk, b_if.wb_we,
                             b_if.wb_addr, b_if.wb_data_out, b_if.rsp_data}, 0);
        rst_a = 1'b0; rst_b = 1'b0;
        tick();

        // Directed write then read against the UART-like timing.
        txn_a(1'b1, 2'd0, 8'hA5, 1, 1);
        txn_a(1'b0, 2'd1, 8'h00, 1, 1);

        // Back-to-back writes with cmd_valid held high.
        for (int i = 0; i < 3; i++) bw[i] = 8'($urandom);
        ack_dly = 1; rel_dly = 1;
        acc_n = 0; low = 0;
        a_if.cmd_valid = 1; a_if.cmd_write = 1; a_if.cmd_addr = 2'd2; a_if.cmd_wdata = bw[0];
        for (int c = 0; c < 40 && acc_n < 3; c++) begin
            bit take;
            take = a_if.cmd_valid && a_if.cmd_ready;
            tick();
            if (take) begin
                ref_mem[a_if.cmd_addr] = a_if.cmd_wdata;
                acc_cyc[acc_n] = c;
                gap_low[acc_n] = low;
                low = 0;
                acc_n++;
                if (acc_n < 3) begin
                    a_if.cmd_addr = 2'(acc_n + 2);
                    a_if.cmd_wdata = bw[acc_n];
                end else a_if.cmd_valid = 0;
            end
            if (!a_if.wb_stb) low++;
        end
        a_if.cmd_valid = 0;
        check("b2b_count", acc_n, 3);
        check("b2b_space1", acc_cyc[1] - acc_cyc[0], 6);
        check("b2b_space2", acc_cyc[2] - acc_cyc[1], 6);
        check("b2b_gap1", gap_low[1] >= 1, 1);
        check("b2b_gap2", gap_low[2] >= 1, 1);
        repeat (8) tick();

        // Randomized traffic; reads return what the reference memory holds.
        for (int i = 0; i < 25; i++)
            txn_a(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 8'($urandom),
                  int'($urandom_range(1, 4)), int'($urandom_range(1, 4)));

        // Timeout in REQ on the TIMEOUT=4 instance: ack never arrives.
        b_if.cmd_valid = 1; b_if.cmd_write = 0; b_if.cmd_addr = 2'd2;
        check("b_ready", b_if.cmd_ready, 1);
        tick();
        b_if.cmd_valid = 0;
        for (lat = 1; lat <= 30; lat++) begin
            tick();
            if (b_if.rsp_valid) break;
        end
        check("req_to_lat", lat, 6);
        check("req_to_err", b_if.rsp_err, 1);
        check("req_to_strb", {b_if.wb_stb, b_if.wb_clk}, 0);
        check("req_to_data", b_if.rsp_data, 8'h00);
        tick();
        check("req_to_pulse", b_if.rsp_valid, 0);
        tick();

        // Read that is acked, then the ack sticks high: REL must abort.
        b_if.wb_data_in = 8'h77;
        b_if.cmd_valid = 1; b_if.cmd_write = 0; b_if.cmd_addr = 2'd3;
        check("b_ready2", b_if.cmd_ready, 1);
        tick();
        b_if.cmd_valid = 0;
        b_if.wb_ack = 1;
        for (lat = 1; lat <= 30; lat++) begin
            tick();
            if (b_if.rsp_valid) break;
        end
        check("rel_to_lat", lat, 7);
        check("rel_to_err", b_if.rsp_err, 1);
        check("rel_to_data", b_if.rsp_data, 8'h77);
        check("rel_to_strb", {b_if.wb_stb, b_if.wb_clk}, 0);
        tick();
        b_if.cmd_valid = 1; b_if.cmd_write = 1; b_if.cmd_addr = 2'd1; b_if.cmd_wdata = 8'h42;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stale_ack_block", {b_if.cmd_ready, b_if.wb_stb}, 0);
        end
        b_if.wb_ack = 0;
        #1;
        check("stale_ack_clear", b_if.cmd_ready, 1);

        // Accept, then reset asynchronously while in REQ.
        tick();
        check("rst_mid_req", {b_if.wb_stb, b_if.wb_clk}, 2'b11);
        #2 rst_b = 1'b1;
        #1;
        check("rst_async_drop", {b_if.wb_stb, b_if.wb_clk, b_if.rsp_valid}, 0);
        b_if.cmd_valid = 0;
        tick();
        rst_b = 1'b0;
        #1;
        check("rst_ready", b_if.cmd_ready, 1);
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (b_if.rsp_valid || b_if.wb_stb) pulses++;
        end
        check("rst_no_rsp", pulses, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
